counter_updn: RTL and testbench

COUNTER_UPDN -- requirements
Module: counter_updn

---
 rtl/counter_updn_if.sv | 39 +++
 rtl/counter_updn.sv | 76 +++++++
 tb/tb_counter_updn.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/counter_updn_if.sv
// Control and data bundle for counter_updn: the master drives controls and load data,
// the slave (the counter) returns the count, ripple carry and wrap pulse.
interface counter_updn_if #(
  parameter int unsigned WIDTH = 16
);
  logic             nCLR;
  logic             nLOAD;
  logic             ENP;
  logic             ENT;
  logic             U_nD;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             RCO;
  logic             WRAP;

  modport master (
    output nCLR,
    output nLOAD,
    output ENP,
    output ENT,
    output U_nD,
    output Din,
    input  Dout,
    input  RCO,
    input  WRAP
  );

  modport slave (
    input  nCLR,
    input  nLOAD,
    input  ENP,
    input  ENT,
    input  U_nD,
    input  Din,
    output Dout,
    output RCO,
    output WRAP
  );
endinterface

// File: rtl/counter_updn.sv
// LS163-style cascadable up/down counter with optional modulus, synchronous clear/load,
// combinational ripple carry/borrow and a registered wrap pulse.
module counter_updn #(
  parameter int unsigned      WIDTH  = 16,
  parameter longint unsigned  MODULO = 0
) (
  input logic           CLK,
  input logic           nRST,
  counter_updn_if.slave bus
);

  localparam logic [WIDTH-1:0] Top = (MODULO == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULO - 64'd1);

  logic [1:0]       rst_sync_q;
  logic             run;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             cnt_en;

  // Reset asserts asynchronously but releases through two flops, so the first
  // synchronous operation lands no earlier than the second edge after release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run    = rst_sync_q[1];
  assign cnt_en = bus.ENP & bus.ENT;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (run) begin
      if (!bus.nCLR) begin
        cnt_d = '0;
      end else if (!bus.nLOAD) begin
        cnt_d = bus.Din;
      end else if (cnt_en) begin
        if (bus.U_nD) begin
          // Out-of-range loaded values wrap to zero on the next up step.
          if (cnt_q >= Top) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = Top;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Dout = cnt_q;
  assign bus.WRAP = wrap_q;
  assign bus.RCO  = bus.ENT & (bus.U_nD ? (cnt_q == Top) : (cnt_q == '0));

endmodule

// File: tb/tb_counter_updn.sv
// Directed bench for counter_updn: vector table on an 8-bit mod-10 instance plus
// sequences for 16-bit wrap, a 2-stage 4-bit cascade and asynchronous reset.
module tb_counter_updn;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;

  counter_updn_if #(.WIDTH(16)) b16 ();
  counter_updn_if #(.WIDTH(8))  b8 ();
  counter_updn_if #(.WIDTH(4))  bc0 ();
  counter_updn_if #(.WIDTH(4))  bc1 ();

  counter_updn #(.WIDTH(16), .MODULO(0))  u16 (.CLK(clk), .nRST(nrst), .bus(b16.slave));
  counter_updn #(.WIDTH(8),  .MODULO(10)) u8  (.CLK(clk), .nRST(nrst), .bus(b8.slave));
  counter_updn #(.WIDTH(4),  .MODULO(0))  uc0 (.CLK(clk), .nRST(nrst), .bus(bc0.slave));
  counter_updn #(.WIDTH(4),  .MODULO(0))  uc1 (.CLK(clk), .nRST(nrst), .bus(bc1.slave));

  // Cascade: shared controls, stage-0 carry feeds stage-1 ENT.
  assign bc1.nCLR  = bc0.nCLR;
  assign bc1.nLOAD = bc0.nLOAD;
  assign bc1.ENP   = bc0.ENP;
  assign bc1.U_nD  = bc0.U_nD;
  assign bc1.ENT   = bc0.RCO;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       nclr;
    logic       nload;
    logic       enp;
    logic       ent;
    logic       und;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rco;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nclr, input logic nload, input logic enp, input logic ent,
                     input logic und, input logic [7:0] din, input logic [7:0] dout,
                     input logic rco, input logic wrap);
    vec_t v;
    v.nclr = nclr; v.nload = nload; v.enp = enp; v.ent = ent; v.und = und;
    v.din = din; v.dout = dout; v.rco = rco; v.wrap = wrap;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nrst    = 1'b0;
    b16.nCLR = 1'b1; b16.nLOAD = 1'b1; b16.ENP = 1'b0; b16.ENT = 1'b0; b16.U_nD = 1'b1;
    b16.Din  = '0;
    b8.nCLR  = 1'b1; b8.nLOAD  = 1'b1; b8.ENP  = 1'b0; b8.ENT  = 1'b0; b8.U_nD  = 1'b1;
    b8.Din   = '0;
    bc0.nCLR = 1'b1; bc0.nLOAD = 1'b1; bc0.ENP = 1'b0; bc0.ENT = 1'b1; bc0.U_nD = 1'b1;
    bc0.Din  = '0;
    bc1.Din  = '0;

    //   nclr nload enp ent und din    dout   rco wrap
    add(1, 0, 1, 1, 0, 8'h02, 8'h02, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h01, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h00, 1, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h09, 0, 1);
    add(1, 1, 1, 1, 0, 8'h00, 8'h08, 0, 0);
    add(1, 0, 1, 1, 1, 8'hC8, 8'hC8, 0, 0);
    add(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1);
    add(1, 0, 1, 1, 0, 8'hC8, 8'hC8, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'hC7, 0, 0);
    add(0, 0, 1, 1, 1, 8'h55, 8'h00, 0, 0);
    add(1, 0, 1, 1, 1, 8'h05, 8'h05, 0, 0);
    add(1, 1, 1, 0, 1, 8'h00, 8'h05, 0, 0);
    add(1, 0, 1, 1, 1, 8'h09, 8'h09, 1, 0);
    add(1, 1, 0, 1, 1, 8'h00, 8'h09, 1, 0);
    add(1, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1);
    add(1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 1, 1, 1, 1, 8'h00, 8'h01, 0, 0);
    add(1, 1, 1, 1, 0, 8'h00, 8'h00, 1, 0);
    add(1, 0, 1, 1, 1, 8'h09, 8'h09, 1, 0);
    add(0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 0);
    add(1, 0, 0, 0, 0, 8'h03, 8'h03, 0, 0);

    #2;
    check("reset_dout16", b16.Dout, 16'h0000);
    check("reset_wrap16", b16.WRAP, 1'b0);
    check("reset_dout8", b8.Dout, 8'h00);
    #10 nrst = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < vecs.size(); i++) begin
      b8.nCLR = vecs[i].nclr; b8.nLOAD = vecs[i].nload; b8.ENP = vecs[i].enp;
      b8.ENT  = vecs[i].ent;  b8.U_nD  = vecs[i].und;   b8.Din = vecs[i].din;
      tick();
      check($sformatf("vec%0d_dout", i), b8.Dout, vecs[i].dout);
      check($sformatf("vec%0d_rco", i), b8.RCO, vecs[i].rco);
      check($sformatf("vec%0d_wrap", i), b8.WRAP, vecs[i].wrap);
    end

    // 16-bit natural wrap
    b16.nLOAD = 1'b0; b16.Din = 16'hFFFE; b16.ENP = 1'b1; b16.ENT = 1'b1; b16.U_nD = 1'b1;
    tick();
    check("w16_load", b16.Dout, 16'hFFFE);
    b16.nLOAD = 1'b1;
    tick();
    check("w16_ffff", b16.Dout, 16'hFFFF);
    check("w16_rco_top", b16.RCO, 1'b1);
    check("w16_nowrap", b16.WRAP, 1'b0);
    tick();
    check("w16_zero", b16.Dout, 16'h0000);
    check("w16_wrap", b16.WRAP, 1'b1);
    check("w16_rco_zero", b16.RCO, 1'b0);
    tick();
    check("w16_one", b16.Dout, 16'h0001);
    check("w16_wrap_end", b16.WRAP, 1'b0);

    // Cascade of two 4-bit stages
    bc0.nLOAD = 1'b0; bc0.Din = 4'hF; bc1.Din = 4'h0; bc0.ENP = 1'b0;
    tick();
    check("casc_load", {bc1.Dout, bc0.Dout}, 8'h0F);
    bc0.nLOAD = 1'b1; bc0.ENP = 1'b1;
    tick();
    check("casc_up", {bc1.Dout, bc0.Dout}, 8'h10);
    bc0.U_nD = 1'b0;
    tick();
    check("casc_down", {bc1.Dout, bc0.Dout}, 8'h0F);
    bc0.ENP = 1'b0;

    // Asynchronous reset between edges while counting
    b16.nLOAD = 1'b0; b16.Din = 16'h1234; b16.U_nD = 1'b1;
    tick();
    check("rst_preload", b16.Dout, 16'h1234);
    b16.nLOAD = 1'b1;
    #3 nrst = 1'b0;
    #1;
    check("rst_async_dout", b16.Dout, 16'h0000);
    check("rst_async_wrap", b16.WRAP, 1'b0);
    b16.U_nD = 1'b0;
    #1;
    check("rst_rco_down", b16.RCO, 1'b1);
    b16.U_nD = 1'b1;
    #1 nrst = 1'b1;
    tick();
    check("rst_edge1", b16.Dout, 16'h0000);
    tick();
    check("rst_edge2", b16.Dout, 16'h0000);
    for (int i = 0; i < 4 && b16.Dout == 16'h0000; i++) tick();
    check("rst_resume", b16.Dout, 16'h0001);
    check("rst_resume_wrap", b16.WRAP, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
